// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with a fixed-latency
// word-addressed backing memory, answering the M-stage load/store handshake.
`timescale 1ns/1ps
module data_cache #(
   parameter int MEM_WORDS     = 1024,
   parameter int CACHE_LINES   = 16,
   parameter int LINE_WORDS    = 4,
   parameter int MISS_LATENCY  = 10,
   parameter int WRITE_LATENCY = 10,
   parameter     INIT_FILE     = ""
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWriteM,
   input  logic        MemtoRegM,
   input  logic [31:0] ALUOutM,
   input  logic [31:0] WriteDataM,
   output logic [31:0] ReadDataM,
   output logic        MemReady
);
   localparam int AW   = $clog2(MEM_WORDS);
   localparam int OW   = $clog2(LINE_WORDS);
   localparam int IW   = $clog2(CACHE_LINES);
   localparam int TW   = AW - OW - IW;
   localparam int MAXL = (MISS_LATENCY > WRITE_LATENCY) ? MISS_LATENCY : WRITE_LATENCY;
   localparam int CW   = (MAXL > 1) ? $clog2(MAXL) : 1;

   typedef enum logic [1:0] {IDLE, RMISS, WBUSY, DONE} state_t;

   state_t          state, next_state;
   logic [CW-1:0]   cnt, next_cnt;

   logic [31:0]     mem        [MEM_WORDS];
   logic [31:0]     cache_data [CACHE_LINES*LINE_WORDS];
   logic [TW-1:0]   tags       [CACHE_LINES];
   logic [CACHE_LINES-1:0] valid;

   logic [AW-1:0]   word_addr;
   logic [OW-1:0]   offset;
   logic [IW-1:0]   index;
   logic [TW-1:0]   tag;
   logic            hit, rd_only, fill_en, commit_en;
   logic            unused_addr_bits;

   assign word_addr        = ALUOutM[AW+1:2];
   assign offset           = word_addr[OW-1:0];
   assign index            = word_addr[OW+IW-1:OW];
   assign tag              = word_addr[AW-1:OW+IW];
   assign unused_addr_bits = &{1'b0, ALUOutM[31:AW+2], ALUOutM[1:0]};

   assign hit       = valid[index] && (tags[index] == tag);
   // A simultaneous read and write request is serviced as a write only.
   assign rd_only   = MemtoRegM && !MemWriteM;
   assign fill_en   = (state == RMISS) && (cnt == '0);
   assign commit_en = (state == WBUSY) && (cnt == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= next_state;
         cnt   <= next_cnt;
      end
   end

   always_comb begin
      next_state = state;
      next_cnt   = cnt;
      case (state)
         IDLE: begin
            if (MemWriteM) begin
               next_state = WBUSY;
               next_cnt   = CW'(WRITE_LATENCY - 1);
            end else if (MemtoRegM && !hit) begin
               next_state = RMISS;
               next_cnt   = CW'(MISS_LATENCY - 1);
            end
         end
         RMISS, WBUSY: begin
            if (cnt == '0) next_state = DONE;
            else           next_cnt   = cnt - 1'b1;
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      MemReady  = 1'b1;
      ReadDataM = '0;
      case (state)
         IDLE:         MemReady = !(MemWriteM || (MemtoRegM && !hit));
         RMISS, WBUSY: MemReady = 1'b0;
         default:      MemReady = 1'b1;
      endcase
      if ((state == IDLE || state == DONE) && rd_only && hit)
         ReadDataM = cache_data[{index, offset}];
   end

   always_ff @(posedge clk) begin
      if (reset)        valid        <= '0;
      else if (fill_en) valid[index] <= 1'b1;
   end

   // Storage arrays carry no reset; the gating on reset keeps an aborted
   // fill or store from landing.
   always_ff @(posedge clk) begin
      if (!reset && commit_en) begin
         mem[word_addr] <= WriteDataM;
         if (hit) cache_data[{index, offset}] <= WriteDataM;
      end
      if (!reset && fill_en) begin
         for (int j = 0; j < LINE_WORDS; j++)
            cache_data[{index, OW'(j)}] <= mem[{tag, index, OW'(j)}];
         tags[index] <= tag;
      end
   end
endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: latency, hit/miss, write-through, conflict and
// reset-abort behaviour with hand-computed expectations.
`timescale 1ns/1ps
module tb_data_cache;
  logic        clk = 1'b0;
  logic        reset;
  logic        MemWriteM, MemtoRegM;
  logic [31:0] ALUOutM, WriteDataM;
  logic [31:0] ReadDataM;
  logic        MemReady;

  int vectors     = 0;
  int miscompares = 0;

  data_cache dut (
    .clk(clk), .reset(reset), .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .ReadDataM(ReadDataM), .MemReady(MemReady)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", name, observed, expected);
    end
  endtask

  task automatic idle_inputs();
    MemWriteM  = 1'b0;
    MemtoRegM  = 1'b0;
    ALUOutM    = '0;
    WriteDataM = '0;
  endtask

  // Apply a request in an IDLE cycle, count cycles until MemReady, check data,
  // then release and step into the following IDLE cycle.
  task automatic access(input string name, input logic we, input logic re,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int exp_lat, input logic [31:0] exp_data);
    int n;
    MemWriteM  = we;
    MemtoRegM  = re;
    ALUOutM    = addr;
    WriteDataM = wd;
    #1;
    n = 0;
    while (!MemReady && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    check({name, " latency"}, 32'(n), 32'(exp_lat));
    check({name, " data"}, ReadDataM, exp_data);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    do_reset();

    // Seed backing memory; the following reset clears valids but keeps memory.
    access("seed 0x100", 1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 11, 32'h0);
    access("seed 0x104", 1'b1, 1'b0, 32'h104, 32'h01040104, 11, 32'h0);
    access("seed 0x300", 1'b1, 1'b0, 32'h300, 32'hCAFEF00D, 11, 32'h0);
    access("seed 0x500", 1'b1, 1'b0, 32'h500, 32'h05000500, 11, 32'h0);
    do_reset();

    #1;
    check("reset MemReady", 32'(MemReady), 32'h1);
    check("reset ReadDataM", ReadDataM, 32'h0);

    access("read miss 0x100", 1'b0, 1'b1, 32'h100, 32'h0, 11, 32'hDEADBEEF);
    access("read hit 0x104",  1'b0, 1'b1, 32'h104, 32'h0, 0,  32'h01040104);
    access("read hit 0x103 byte bits", 1'b0, 1'b1, 32'h103, 32'h0, 0, 32'hDEADBEEF);

    access("write hit 0x100", 1'b1, 1'b0, 32'h100, 32'h12345678, 11, 32'h0);
    access("read hit after write", 1'b0, 1'b1, 32'h100, 32'h0, 0, 32'h12345678);

    // 0x2000 wraps onto word 0 (index 0, tag 0), evicting the 0x100 line.
    access("write miss 0x2000", 1'b1, 1'b0, 32'h2000, 32'hA5A5A5A5, 11, 32'h0);
    access("read miss 0x2000",  1'b0, 1'b1, 32'h2000, 32'h0, 11, 32'hA5A5A5A5);
    access("read wrap 0x0 hit", 1'b0, 1'b1, 32'h0, 32'h0, 0, 32'hA5A5A5A5);

    access("conflict 0x100", 1'b0, 1'b1, 32'h100, 32'h0, 11, 32'h12345678);
    access("conflict 0x500", 1'b0, 1'b1, 32'h500, 32'h0, 11, 32'h05000500);
    access("conflict 0x100 again", 1'b0, 1'b1, 32'h100, 32'h0, 11, 32'h12345678);

    // Reset during the fifth cycle of a store: nothing must be committed.
    MemWriteM  = 1'b1;
    ALUOutM    = 32'h300;
    WriteDataM = 32'h1;
    for (int i = 0; i < 4; i++) @(negedge clk);
    #1;
    check("mid-write MemReady", 32'(MemReady), 32'h0);
    check("mid-write ReadDataM", ReadDataM, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort MemReady", 32'(MemReady), 32'h1);
    @(negedge clk);
    access("read after abort 0x300", 1'b0, 1'b1, 32'h300, 32'h0, 11, 32'hCAFEF00D);

    // Write and read together behave as a write; data returns zero.
    MemWriteM  = 1'b1;
    MemtoRegM  = 1'b1;
    ALUOutM    = 32'h300;
    WriteDataM = 32'h77;
    #1;
    check("wr+rd MemReady idle", 32'(MemReady), 32'h0);
    check("wr+rd ReadDataM idle", ReadDataM, 32'h0);
    access("wr+rd 0x300", 1'b1, 1'b1, 32'h300, 32'h77, 11, 32'h0);
    access("read hit 0x300 updated", 1'b0, 1'b1, 32'h300, 32'h0, 0, 32'h77);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
